// File: rtl/SB_codex_pkg.sv
// Sideband message types shared by the SB_TX/SB_RX path: opcodes, header struct,
// well-known messages and the payload normalisation helpers.
package SB_codex_pkg;

    typedef enum logic [4:0] {
        MemRead_32b                      = 5'b00000,
        MemWrite_32b                     = 5'b00001,
        DMSRegRead_32b                   = 5'b00010,
        DMSRegWrite_32b                  = 5'b00011,
        ConfigRead_32b                   = 5'b00100,
        ConfigWrite_32b                  = 5'b00101,
        MemRead_64b                      = 5'b01000,
        MemWrite_64b                     = 5'b01001,
        DMSRegRead_64b                   = 5'b01010,
        DMSRegWrite_64b                  = 5'b01011,
        ConfigRead_64b                   = 5'b01100,
        ConfigWrite_64b                  = 5'b01101,
        Completion_without_Data          = 5'b10000,
        Completion_with_32b_Data         = 5'b10001,
        Message_without_Data             = 5'b10010,
        Management_Port_Msg_without_Data = 5'b10111,
        Management_Port_Msg_with_Data    = 5'b11000,
        Completion_with_64b_Data         = 5'b11001,
        Message_with_64b_Data            = 5'b11011
    } opcode_t;

    typedef struct packed {
        opcode_t     opcode;
        logic [7:0]  msg_code;
        logic [15:0] msg_info;
        logic [7:0]  msg_subcode;
    } SB_msg_t;

    localparam int SB_DATA_W = 64;

    // One queue slot: header plus the already-normalised payload.
    typedef struct packed {
        SB_msg_t               msg;
        logic [SB_DATA_W-1:0]  data;
    } sb_entry_t;

    localparam SB_msg_t SBINIT_OUT_OF_RESET = '{opcode: Message_without_Data,
        msg_code: 8'h91, msg_info: 16'h0000, msg_subcode: 8'h00};
    localparam SB_msg_t SBINIT_DONE_REQ = '{opcode: Message_without_Data,
        msg_code: 8'h95, msg_info: 16'h0000, msg_subcode: 8'h01};

    function automatic SB_msg_t reset_SB_msg();
        SB_msg_t m;
        m = '0;
        return m;
    endfunction

    function automatic logic sb_is_32b_op(opcode_t opcode);
        case (opcode)
            MemRead_32b, MemWrite_32b, DMSRegRead_32b,
            DMSRegWrite_32b, ConfigRead_32b, ConfigWrite_32b: return 1'b1;
            default:                                          return 1'b0;
        endcase
    endfunction

    // Used by the receive-side checks; normalisation only zeroes Message_without_Data.
    function automatic logic sb_has_data(opcode_t opcode);
        case (opcode)
            Completion_without_Data, Message_without_Data,
            Management_Port_Msg_without_Data:                 return 1'b0;
            default:                                          return 1'b1;
        endcase
    endfunction

    function automatic logic [SB_DATA_W-1:0] sb_norm_data(opcode_t opcode,
                                                          logic [SB_DATA_W-1:0] d);
        if (sb_is_32b_op(opcode))
            return {32'd0, d[31:0]};
        else if (opcode == Message_without_Data)
            return '0;
        else
            return d;
    endfunction

endpackage

// File: rtl/sb_msg_fifo.sv
// Generic DEPTH x W synchronous FIFO; full/empty come from the occupancy count,
// pointers wrap naturally because DEPTH is a power of two.
module sb_msg_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 8,
    parameter int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush_i,
    input  logic             wr_en_i,
    input  logic [W-1:0]     wr_data_i,
    input  logic             rd_en_i,
    output logic [W-1:0]     rd_data_o,
    output logic [CNT_W-1:0] count_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [W-1:0]     mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             wr_fire, rd_fire;

    assign full_o    = (count_q == CNT_W'(DEPTH));
    assign empty_o   = (count_q == '0);
    assign count_o   = count_q;
    assign rd_data_o = mem_q[rd_ptr_q];

    assign wr_fire = wr_en_i && !full_o && !flush_i;
    assign rd_fire = rd_en_i && !empty_o && !flush_i;

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (wr_fire) wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (rd_fire) rd_ptr_d = rd_ptr_q + PTR_W'(1);
            case ({wr_fire, rd_fire})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // NOTE: storage has no reset; count gates every read, so stale contents are never observed.
    always_ff @(posedge clk) begin
        if (wr_fire)
            mem_q[wr_ptr_q] <= wr_data_i;
    end

endmodule

// File: rtl/sb_tx_msg_queue.sv
// Sideband message queue feeding SB_TX: normalises payloads on entry and hands out
// one registered message per send_next request.
module sb_tx_msg_queue
    import SB_codex_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic                 clk_100MHz,
    input  logic                 reset_n,
    input  logic                 enable_i,
    input  logic                 flush_i,
    input  logic                 push_i,
    input  SB_msg_t              msg_i,
    input  logic [SB_DATA_W-1:0] data_i,
    output logic                 full_o,
    output logic [CNT_W-1:0]     count_o,
    output logic                 overflow_o,
    input  logic                 send_next_i,
    output logic                 valid_o,
    output SB_msg_t              SB_msg_o,
    output logic [SB_DATA_W-1:0] data_o
);

    sb_entry_t            wr_entry, head_entry;
    logic                 fifo_full, fifo_empty;
    logic                 push_ok, pop;

    logic                 valid_q, valid_d;
    SB_msg_t              msg_q, msg_d;
    logic [SB_DATA_W-1:0] data_q, data_d;
    logic                 overflow_q, overflow_d;

    assign wr_entry = '{msg: msg_i, data: sb_norm_data(msg_i.opcode, data_i)};

    // Decisions use registered occupancy, so an empty queue never bypasses a same-cycle push.
    assign push_ok = push_i && !fifo_full;
    assign pop     = enable_i && send_next_i && !fifo_empty;

    sb_msg_fifo #(
        .DEPTH (DEPTH),
        .W     ($bits(sb_entry_t)),
        .CNT_W (CNT_W)
    ) u_fifo (
        .clk       (clk_100MHz),
        .rst_n     (reset_n),
        .flush_i   (flush_i),
        .wr_en_i   (push_ok),
        .wr_data_i (wr_entry),
        .rd_en_i   (pop),
        .rd_data_o (head_entry),
        .count_o   (count_o),
        .full_o    (fifo_full),
        .empty_o   (fifo_empty)
    );

    always_comb begin
        valid_d    = 1'b0;
        msg_d      = msg_q;
        data_d     = data_q;
        overflow_d = overflow_q;
        if (flush_i) begin
            overflow_d = 1'b0;
        end else begin
            if (pop) begin
                valid_d = 1'b1;
                msg_d   = head_entry.msg;
                data_d  = head_entry.data;
            end
            if (push_i && fifo_full)
                overflow_d = 1'b1;
        end
    end

    always_ff @(posedge clk_100MHz or negedge reset_n) begin
        if (!reset_n) begin
            valid_q    <= 1'b0;
            msg_q      <= reset_SB_msg();
            data_q     <= '0;
            overflow_q <= 1'b0;
        end else begin
            valid_q    <= valid_d;
            msg_q      <= msg_d;
            data_q     <= data_d;
            overflow_q <= overflow_d;
        end
    end

    assign full_o     = fifo_full;
    assign overflow_o = overflow_q;
    assign valid_o    = valid_q;
    assign SB_msg_o   = msg_q;
    assign data_o     = data_q;

endmodule
